// File: rtl/cache_line_fill_if.sv
// cache_line_fill_if: bundles the request, SDRAM burst and cache-RAM write-port
// signals of cache_line_fill.
//   master : fill requester / SDRAM side (drives req, req_addr, abort,
//            sdram_valid, sdram_data; observes the fill outputs)
//   slave  : the line-fill engine itself
// Parameters depth/width must match the cache_line_fill instance using it.
interface cache_line_fill_if #(
  parameter int unsigned depth = 8,
  parameter int unsigned width = 32
);
  logic             req;
  logic [depth-1:0] req_addr;
  logic             abort;
  logic             sdram_valid;
  logic [width-1:0] sdram_data;
  logic             busy;
  logic             ram_wren;
  logic [depth-1:0] ram_address;
  logic [width-1:0] ram_data;
  logic             crit_valid;
  logic [width-1:0] crit_data;
  logic             done;

  modport master (
    output req, req_addr, abort, sdram_valid, sdram_data,
    input  busy, ram_wren, ram_address, ram_data, crit_valid, crit_data, done
  );

  modport slave (
    input  req, req_addr, abort, sdram_valid, sdram_data,
    output busy, ram_wren, ram_address, ram_data, crit_valid, crit_data, done
  );
endinterface

// File: rtl/cache_line_fill.sv
// cache_line_fill: writes one cache line into the cache data RAM from an SDRAM
// burst delivered critical-word-first. The requested word address is latched;
// each accepted burst word is written one cycle later at {base, offset}, where
// offset wraps inside the line. The critical (first) word is flagged with
// crit_valid/crit_data and the last word with done.
// Ports:
//   clock, reset          : rising-edge clock, async active-high reset
//   bus (slave modport)   : req/req_addr/abort, sdram_valid/sdram_data in;
//                           busy, ram_wren/ram_address/ram_data,
//                           crit_valid/crit_data, done out (all registered)
module cache_line_fill #(
  parameter int unsigned depth    = 8,
  parameter int unsigned width    = 32,
  parameter int unsigned linebits = 2
) (
  input logic               clock,
  input logic               reset,
  cache_line_fill_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StFill} state_e;

  localparam int unsigned BaseBits = depth - linebits;

  // Count value of the final word of the line (2^linebits - 1).
  localparam logic [linebits:0]   CountLast = {1'b0, {linebits{1'b1}}};
  localparam logic [linebits:0]   CountOne  = 1;
  localparam logic [linebits-1:0] OffsetOne = 1;

  state_e              state_q, state_d;
  logic [BaseBits-1:0] base_q, base_d;
  logic [linebits-1:0] offset_q, offset_d;
  logic [linebits:0]   count_q, count_d;

  logic                busy_q, busy_d;
  logic                wren_q, wren_d;
  logic [depth-1:0]    addr_q, addr_d;
  logic [width-1:0]    data_q, data_d;
  logic                crit_valid_q, crit_valid_d;
  logic [width-1:0]    crit_data_q, crit_data_d;
  logic                done_q, done_d;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    offset_d     = offset_q;
    count_d      = count_q;
    wren_d       = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    crit_valid_d = 1'b0;
    crit_data_d  = crit_data_q;
    done_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        // sdram_valid is deliberately ignored here, including in the req cycle.
        if (bus.req) begin
          state_d  = StFill;
          base_d   = bus.req_addr[depth-1:linebits];
          offset_d = bus.req_addr[linebits-1:0];
          count_d  = '0;
        end
      end
      StFill: begin
        if (bus.abort) begin
          // Any word arriving with abort is dropped.
          state_d = StIdle;
        end else if (bus.sdram_valid) begin
          wren_d   = 1'b1;
          addr_d   = {base_q, offset_q};
          data_d   = bus.sdram_data;
          offset_d = offset_q + OffsetOne;  // wraps within the line
          count_d  = count_q + CountOne;
          if (count_q == '0) begin
            crit_valid_d = 1'b1;
            crit_data_d  = bus.sdram_data;
          end
          if (count_q == CountLast) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StFill);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      base_q       <= '0;
      offset_q     <= '0;
      count_q      <= '0;
      busy_q       <= 1'b0;
      wren_q       <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      offset_q     <= offset_d;
      count_q      <= count_d;
      busy_q       <= busy_d;
      wren_q       <= wren_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      crit_valid_q <= crit_valid_d;
      crit_data_q  <= crit_data_d;
      done_q       <= done_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.ram_wren    = wren_q;
  assign bus.ram_address = addr_q;
  assign bus.ram_data    = data_q;
  assign bus.crit_valid  = crit_valid_q;
  assign bus.crit_data   = crit_data_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_cache_line_fill.sv
// Bench for cache_line_fill: table of fill vectors plus hand-written abort,
// back-to-back, idle and reset sequences. Expected writes are queued when a
// burst word is driven and compared when the DUT writes.
module tb_cache_line_fill;

  logic clock;
  logic reset;

  cache_line_fill_if #(.depth(8), .width(32)) bus ();

  cache_line_fill #(.depth(8), .width(32), .linebits(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic        crit;
    logic        done;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [7:0]       addr;
    logic [31:0]      d0;
    logic [15:0]      mask;      // relative cycles carrying sdram_valid
    logic [3:0][7:0]  exp_addr;  // [n] = address of n-th write
    int               busy_req;  // relative cycle of a req while busy, -1 none
  } vec_t;

  exp_t sb[$];
  int   checks;
  int   errors;
  int   cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  task automatic monitor_step();
    exp_t e;
    checks++;
    if (bus.ram_wren) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write cyc=%0d addr=%h data=%h", cyc, bus.ram_address,
                 bus.ram_data);
      end else begin
        e = sb.pop_front();
        if (bus.ram_address !== e.addr || bus.ram_data !== e.data ||
            bus.crit_valid !== e.crit || bus.done !== e.done || bus.busy !== !e.done ||
            cyc != e.cyc || (e.crit && bus.crit_data !== e.data)) begin
          errors++;
          $display("FAIL write got cyc=%0d addr=%h data=%h crit=%b/%h done=%b busy=%b want cyc=%0d addr=%h data=%h crit=%b done=%b busy=%b",
                   cyc, bus.ram_address, bus.ram_data, bus.crit_valid, bus.crit_data,
                   bus.done, bus.busy, e.cyc, e.addr, e.data, e.crit, e.done, !e.done);
        end
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      errors++;
      $display("FAIL missing_write cyc=%0d want addr=%h at cyc=%0d", cyc, sb[0].addr, sb[0].cyc);
      e = sb.pop_front();
    end else if (bus.crit_valid || bus.done) begin
      errors++;
      $display("FAIL stray_pulse cyc=%0d crit=%b done=%b want 0 0", cyc, bus.crit_valid,
               bus.done);
    end
  endtask

  // Check outputs at the falling edge, then advance to just after the next rising edge.
  task automatic tick();
    @(negedge clock);
    monitor_step();
    @(posedge clock);
    cyc++;
    #1;
  endtask

  task automatic push_exp(input logic [7:0] a, input logic [31:0] d, input logic c,
                          input logic dn);
    exp_t e;
    e.addr = a; e.data = d; e.crit = c; e.done = dn; e.cyc = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    bus.req = 1'b0; bus.abort = 1'b0; bus.sdram_valid = 1'b0;
  endtask

  task automatic run_fill(input vec_t v);
    int n;
    bus.req = 1'b1; bus.req_addr = v.addr; bus.sdram_valid = 1'b0;
    tick();
    n = 0;
    for (int rel = 1; rel < 16 && n < 4; rel++) begin
      bus.req      = (rel == v.busy_req);
      bus.req_addr = bus.req ? ~v.addr : v.addr;
      if (v.mask[rel]) begin
        bus.sdram_valid = 1'b1;
        bus.sdram_data  = v.d0 + n;
        push_exp(v.exp_addr[n], v.d0 + n, n == 0, n == 3);
        n++;
      end else begin
        bus.sdram_valid = 1'b0;
      end
      tick();
    end
    idle_inputs();
    tick();
    tick();
  endtask

  vec_t vecs[4];
  vec_t v;

  initial begin
    checks = 0; errors = 0; cyc = 0;
    bus.req = 1'b0; bus.req_addr = '0; bus.abort = 1'b0;
    bus.sdram_valid = 1'b0; bus.sdram_data = '0;

    vecs[0] = '{addr: 8'h40, d0: 32'hA0, mask: 16'h001E,
                exp_addr: {8'h43, 8'h42, 8'h41, 8'h40}, busy_req: -1};
    vecs[1] = '{addr: 8'h42, d0: 32'hB0, mask: 16'h001E,
                exp_addr: {8'h41, 8'h40, 8'h43, 8'h42}, busy_req: -1};
    vecs[2] = '{addr: 8'hFF, d0: 32'hC0, mask: 16'h0264,
                exp_addr: {8'hFE, 8'hFD, 8'hFC, 8'hFF}, busy_req: -1};
    vecs[3] = '{addr: 8'h58, d0: 32'hD0, mask: 16'h001E,
                exp_addr: {8'h5B, 8'h5A, 8'h59, 8'h58}, busy_req: 2};

    // Reset state.
    reset = 1'b0;
    #1 reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("rst_busy", {31'b0, bus.busy}, 0);
    chk("rst_wren", {31'b0, bus.ram_wren}, 0);
    chk("rst_addr", {24'b0, bus.ram_address}, 0);
    chk("rst_data", bus.ram_data, 0);
    chk("rst_crit_valid", {31'b0, bus.crit_valid}, 0);
    chk("rst_crit_data", bus.crit_data, 0);
    chk("rst_done", {31'b0, bus.done}, 0);
    reset = 1'b0;

    // sdram_valid while idle must not write.
    bus.sdram_valid = 1'b1; bus.sdram_data = 32'h5555;
    for (int i = 0; i < 3; i++) tick();
    idle_inputs();
    tick();

    for (int i = 0; i < 4; i++) run_fill(vecs[i]);

    // Abort after two words; word in the abort cycle is dropped.
    bus.req = 1'b1; bus.req_addr = 8'h10;
    tick();
    bus.req = 1'b0;
    bus.sdram_valid = 1'b1; bus.sdram_data = 32'h90; push_exp(8'h10, 32'h90, 1'b1, 1'b0);
    tick();
    bus.sdram_data = 32'h91; push_exp(8'h11, 32'h91, 1'b0, 1'b0);
    tick();
    bus.sdram_data = 32'h92; bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_busy", {31'b0, bus.busy}, 0);
    bus.sdram_data = 32'h93;
    for (int i = 0; i < 3; i++) tick();
    idle_inputs();
    tick();

    // Back-to-back fills: req with the last word is ignored, req in the done cycle starts.
    bus.req = 1'b1; bus.req_addr = 8'h80;
    tick();
    bus.req = 1'b0;
    for (int n = 0; n < 4; n++) begin
      bus.sdram_valid = 1'b1;
      bus.sdram_data  = 32'h70 + n;
      push_exp(8'h80 + n[7:0], 32'h70 + n, n == 0, n == 3);
      if (n == 3) begin
        bus.req = 1'b1; bus.req_addr = 8'h08;
      end
      tick();
    end
    bus.sdram_valid = 1'b0; bus.req = 1'b1; bus.req_addr = 8'h86;
    tick();
    bus.req = 1'b0;
    chk("b2b_busy", {31'b0, bus.busy}, 1);
    begin
      logic [3:0][7:0] b2b;
      b2b = {8'h85, 8'h84, 8'h87, 8'h86};
      for (int n = 0; n < 4; n++) begin
        bus.sdram_valid = 1'b1;
        bus.sdram_data  = 32'h60 + n;
        push_exp(b2b[n], 32'h60 + n, n == 0, n == 3);
        tick();
      end
    end
    idle_inputs();
    tick();
    tick();

    // Reset mid-fill after one write.
    bus.req = 1'b1; bus.req_addr = 8'h30;
    tick();
    bus.req = 1'b0;
    bus.sdram_valid = 1'b1; bus.sdram_data = 32'hE0; push_exp(8'h30, 32'hE0, 1'b1, 1'b0);
    tick();
    bus.sdram_valid = 1'b0;
    tick();
    chk("pre_reset_busy", {31'b0, bus.busy}, 1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_busy", {31'b0, bus.busy}, 0);
    chk("mid_rst_wren", {31'b0, bus.ram_wren}, 0);
    chk("mid_rst_addr", {24'b0, bus.ram_address}, 0);
    chk("mid_rst_data", bus.ram_data, 0);
    chk("mid_rst_crit_data", bus.crit_data, 0);
    chk("mid_rst_crit_valid", {31'b0, bus.crit_valid}, 0);
    chk("mid_rst_done", {31'b0, bus.done}, 0);
    @(posedge clock);
    cyc++;
    #1 reset = 1'b0;

    v = '{addr: 8'h20, d0: 32'hF0, mask: 16'h001E,
          exp_addr: {8'h23, 8'h22, 8'h21, 8'h20}, busy_req: -1};
    run_fill(v);

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the bench never hangs.
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cache_line_fill.md
# cache_line_fill

Fills one cache line in the dual-port cache data RAM from an SDRAM burst. It latches a requested word address, takes incoming burst words with critical-word-first wrap order, and drives a RAM write port (wren/address/data) once per word. It flags the critical word to the CPU side as soon as that word is written and pulses completion on the last word. It sits between the SDRAM controller's read-data path and one write port of the cache data RAM.

## Interface
Parameters:
- depth, 8: RAM word-address width; matches the cache RAM's address width.
- width, 32: data word width.
- linebits, 2: log2 of words per line (2 gives 4 words); must be at least 1 and less than depth.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  start fill; sampled only in IDLE.
- req_addr  in  depth  word address of the critical word.
- abort  in  1  cancel the fill in progress; sampled only in FILL.
- sdram_valid  in  1  one burst word is present on sdram_data this cycle.
- sdram_data  in  width  burst data word.
- busy  out  1  high while in FILL.
- ram_wren  out  1  write strobe to the cache RAM port.
- ram_address  out  depth  RAM word address.
- ram_data  out  width  RAM write data.
- crit_valid  out  1  one-cycle pulse when the critical word is written.
- crit_data  out  width  critical word; valid while crit_valid is high and held until the next fill.
- done  out  1  one-cycle pulse on the last word write.

## Operation
- All outputs are registered. Reset value of every output is 0. The state resets to IDLE, and the internal base, offset and count registers reset to 0.
- States:
  - IDLE: waits for req.
  - FILL: accepts burst words.
- Transition IDLE to FILL on req:
  - base <= req_addr[depth-1:linebits].
  - offset <= req_addr[linebits-1:0].
  - count <= 0.
  - sdram_valid in that same cycle is ignored.
- In FILL, each cycle with sdram_valid high and abort low:
  - Next cycle: ram_wren=1, ram_address={base, offset}, ram_data=sdram_data.
  - offset <= offset+1, modulo 2^linebits. The wrap stays inside the line; base never changes.
  - count <= count+1, a (linebits+1)-bit counter.
  - If count was 0, crit_valid=1 and crit_data=sdram_data in the same cycle as the ram_wren.
  - If count was 2^linebits-1, done=1 in the same cycle as the ram_wren, and the state returns to IDLE, so busy=0 in that same cycle.
- Cycles without sdram_valid: ram_wren=0. Gaps between burst words are allowed.
- abort in FILL: return to IDLE next cycle with busy=0. A sdram_valid in the abort cycle is dropped. No done pulse, and no further writes.
- req while busy is ignored, with no queuing.
- sdram_valid while IDLE is ignored, with no write.
- Asynchronous reset mid-fill: immediately IDLE, all outputs 0, and the partial line is abandoned.
- ram_address and ram_data hold their last values when ram_wren=0. Only ram_wren qualifies them.

## Timing
- req at cycle 0: busy=1 at cycle 1. The first accepted sdram_valid can occur at cycle 1.
- Write latency: sdram_valid at cycle n gives ram_wren at n+1.
- Throughput: one word per cycle. A back-to-back burst of 2^linebits words starting at cycle n ends with done at n+2^linebits.
- done and busy falling coincide. A req in that same cycle is accepted, so the next fill can start without a gap.
- req in the same cycle as the last sdram_valid is ignored, because the state is still FILL.
- crit_valid and done coincide when 2^linebits=1. That case is excluded by linebits>=1.

## Test plan
- Aligned fill: req_addr=0x40, then 4 back-to-back valids with data 0xA0..0xA3.
  - Required: writes to 0x40,0x41,0x42,0x43 with data A0..A3 on consecutive cycles.
  - crit_valid with crit_data=0xA0 on the first write; done on the 4th write; busy low in the same cycle as done.
- Wrap fill: req_addr=0x42, data 0xB0..0xB3.
  - Required: writes to 0x42,0x43,0x40,0x41; crit_data=0xB0; base stays 0x40.
- Gapped burst: req_addr=0xFF, valids at cycles 2,5,6,9.
  - Required: writes at cycles 3,6,7,10 to 0xFF,0xFC,0xFD,0xFE; done at cycle 10.
- Abort: req_addr=0x10, 2 valids, then abort in the same cycle as a 3rd valid.
  - Required: exactly 2 writes (0x10,0x11); no done; busy=0 the next cycle; later valids cause no writes.
- Ignore rules:
  - sdram_valid in IDLE gives no ram_wren.
  - req while busy does not change the address sequence.
  - req in the done cycle starts a new fill, with busy=1 the following cycle.
- Reset mid-fill: assert reset after 1 write.
  - Required: all outputs 0 immediately, without waiting for a clock edge.
  - After release, a fresh req with req_addr=0x20 fills 0x20..0x23 normally.
